// File: rtl/multi_phase_sync_buf.sv
// N-phase RF receive buffer: per-phase strobed shift registers with sticky pulse
// capture, sync-pattern detect and a level/ack packet handshake.
// Optional build macro SYNC_ERR_TOL_EN: tolerate up to MAX_ERR masked sync mismatches.

module mpsb_phase #(
  parameter int             W         = 64,
  parameter logic [W-1:0]   SYNC_MASK = 64'h7C00_001F_0000_001F,
  parameter logic [W-1:0]   SYNC_PAT  = 64'h7C00_001F_0000_001F,
  parameter int             MAX_ERR   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rfin,
  input  logic         sh_en,
  output logic [W-1:0] sr,
  output logic         match
);
  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt;
  logic          hit;
  logic          sh_prev;
  logic          shift;
  logic          full;
  logic [W-1:0]  diff;

  assign shift = sh_en & ~sh_prev;
  assign full  = (cnt == CW'(W));
  assign diff  = (sr ^ SYNC_PAT) & SYNC_MASK;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr      <= '0;
      cnt     <= '0;
      hit     <= 1'b0;
      sh_prev <= 1'b0;
    end else begin
      sh_prev <= sh_en;
      // a pulse coinciding with the shift is folded into the shifted bit
      hit     <= shift ? 1'b0 : (hit | rfin);
      if (match) begin
        sr  <= '0;
        cnt <= '0;
      end else if (shift) begin
        sr <= {sr[W-2:0], hit | rfin};
        if (!full) cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef SYNC_ERR_TOL_EN
  logic [CW-1:0] nerr;
  always_comb begin
    nerr = '0;
    for (int i = 0; i < W; i++) nerr = nerr + CW'(diff[i]);
  end
  assign match = full && (int'(nerr) <= MAX_ERR);
`else
  // a negative tolerance disables detection in either build
  assign match = full && (diff == '0) && (MAX_ERR >= 0);
`endif
endmodule

module multi_phase_sync_buf #(
  parameter int           N_PH      = 4,
  parameter int           W         = 64,
  parameter logic [W-1:0] SYNC_MASK = 64'h7C00_001F_0000_001F,
  parameter logic [W-1:0] SYNC_PAT  = 64'h7C00_001F_0000_001F,
  parameter int           MAX_ERR   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rfin,
  input  logic [N_PH-1:0]         sh_en,
  input  logic                    pkt_ack,
  output logic [W-1:0]            dout,
  output logic                    pkt_rec,
  output logic [$clog2(N_PH)-1:0] ph_idx,
  output logic                    dup,
  output logic                    overrun
);
  localparam int PW = $clog2(N_PH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [N_PH-1:0][W-1:0] sr;
  logic [N_PH-1:0]        match;
  logic [PW-1:0]          win;
  logic                   any_match;
  logic                   multi;
  logic [0:0]             state;

  for (genvar p = 0; p < N_PH; p++) begin : g_ph
    mpsb_phase #(
      .W(W), .SYNC_MASK(SYNC_MASK), .SYNC_PAT(SYNC_PAT), .MAX_ERR(MAX_ERR)
    ) u_ph (
      .clk   (clk),
      .rst   (rst),
      .rfin  (rfin),
      .sh_en (sh_en[p]),
      .sr    (sr[p]),
      .match (match[p])
    );
  end

  // lowest matching phase wins
  always_comb begin
    win = '0;
    for (int p = N_PH - 1; p >= 0; p--) if (match[p]) win = PW'(p);
  end

  assign any_match = |match;
  assign multi     = |(match & (match - 1'b1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      dout    <= '0;
      pkt_rec <= 1'b0;
      ph_idx  <= '0;
      dup     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (any_match) begin
          dout    <= sr[win];
          ph_idx  <= win;
          dup     <= multi;
          pkt_rec <= 1'b1;
          state   <= S_HOLD;
        end
        S_HOLD: if (pkt_ack) begin
          pkt_rec <= 1'b0;
          overrun <= 1'b0;
          state   <= S_IDLE;
        end else if (any_match) begin
          overrun <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_phase_sync_buf.sv
// Directed + randomized bench for multi_phase_sync_buf against a queue-based reference model.
module tb_multi_phase_sync_buf;
  localparam int           N_PH    = 4;
  localparam int           W       = 64;
  localparam logic [W-1:0] MASK    = 64'h7C00_001F_0000_001F;
  localparam logic [W-1:0] PAT     = 64'h7C00_001F_0000_001F;
  localparam int           MAX_ERR = 1;
  localparam logic [W-1:0] F1      = 64'h7C15_A01F_0123_401F;
  localparam logic [W-1:0] T6      = 64'h7E5A_C31F_9AB0_001F;

  logic            clk = 1'b0;
  logic            rst;
  logic            rfin;
  logic [N_PH-1:0] sh_en;
  logic            pkt_ack;
  logic [W-1:0]    dout;
  logic            pkt_rec;
  logic [1:0]      ph_idx;
  logic            dup;
  logic            overrun;

  int errs   = 0;
  int checks = 0;

  // reference model: received bit history per phase (oldest first)
  bit           mq [N_PH][$];
  bit           m_pend [N_PH];
  bit           m_prev [N_PH];
  logic [W-1:0] m_dout;
  bit           m_pkt, m_ovr, m_dup;
  int           m_ph;

  multi_phase_sync_buf #(
    .N_PH(N_PH), .W(W), .SYNC_MASK(MASK), .SYNC_PAT(PAT), .MAX_ERR(MAX_ERR)
  ) dut (
    .clk(clk), .rst(rst), .rfin(rfin), .sh_en(sh_en), .pkt_ack(pkt_ack),
    .dout(dout), .pkt_rec(pkt_rec), .ph_idx(ph_idx), .dup(dup), .overrun(overrun)
  );

  always #50 clk = ~clk;

  function automatic logic [W-1:0] hist(int p);
    logic [W-1:0] v = '0;
    for (int i = 0; i < mq[p].size(); i++) v = {v[W-2:0], mq[p][i]};
    return v;
  endfunction

  function automatic bit m_match(int p);
    int n;
    if (mq[p].size() != W) return 1'b0;
    n = $countones((hist(p) ^ PAT) & MASK);
`ifdef SYNC_ERR_TOL_EN
    return n <= MAX_ERR;
`else
    return n == 0;
`endif
  endfunction

  task automatic model_reset();
    for (int p = 0; p < N_PH; p++) begin
      mq[p].delete();
      m_pend[p] = 1'b0;
      m_prev[p] = 1'b0;
    end
    m_dout = '0; m_pkt = 1'b0; m_ovr = 1'b0; m_dup = 1'b0; m_ph = 0;
  endtask

  task automatic model_edge();
    bit mt [N_PH];
    int nm = 0;
    int first = -1;
    bit rise;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int p = 0; p < N_PH; p++) begin
      mt[p] = m_match(p);
      if (mt[p]) begin
        nm++;
        if (first < 0) first = p;
      end
    end
    if (!m_pkt) begin
      if (nm > 0) begin
        m_dout = hist(first); m_ph = first; m_dup = (nm > 1); m_pkt = 1'b1;
      end
    end else if (pkt_ack) begin
      m_pkt = 1'b0; m_ovr = 1'b0;
    end else if (nm > 0) begin
      m_ovr = 1'b1;
    end
    for (int p = 0; p < N_PH; p++) begin
      rise = sh_en[p] && !m_prev[p];
      if (mt[p]) mq[p].delete();
      else if (rise) begin
        mq[p].push_back(m_pend[p] | rfin);
        if (mq[p].size() > W) void'(mq[p].pop_front());
      end
      m_pend[p] = rise ? 1'b0 : (m_pend[p] | rfin);
      m_prev[p] = sh_en[p];
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pkt_rec", 64'(pkt_rec), 64'(m_pkt));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("dout", dout, m_dout);
    chk("ph_idx", 64'(ph_idx), 64'(m_ph));
    chk("dup", 64'(dup), 64'(m_dup));
  endtask

  task automatic cyc(input logic rf, input logic [N_PH-1:0] se, input logic ack);
    rfin = rf; sh_en = se; pkt_ack = ack;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic send_bits(input logic [W-1:0] fr, input logic [N_PH-1:0] pm, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      cyc(fr[i], pm, 1'b0);
      cyc(1'b0, '0, 1'b0);
    end
  endtask

  task automatic send(input logic [W-1:0] fr, input logic [N_PH-1:0] pm, input logic ack_last);
    send_bits(fr, pm, W - 1, 1);
    cyc(fr[0], pm, 1'b0);
    cyc(1'b0, '0, ack_last);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    logic [W-1:0] fr;
    rst = 1'b0; rfin = 1'b0; sh_en = '0; pkt_ack = 1'b0;
    model_reset();
    #10 check_all();
    cyc(1'b0, '0, 1'b0);
    rst = 1'b1;
    cyc(1'b0, '0, 1'b1);

    // single phase capture
    send(F1, 4'b0001, 1'b0);
    chk("t1_pkt", 64'(pkt_rec), 64'd1);
    chk("t1_dout", dout, F1);
    chk("t1_ph", 64'(ph_idx), 64'd0);
    chk("t1_dup", 64'(dup), 64'd0);

    // second match while holding is dropped
    send(F1, 4'b1000, 1'b0);
    chk("t3_ovr", 64'(overrun), 64'd1);
    chk("t3_dout", dout, F1);
    chk("t3_ph", 64'(ph_idx), 64'd0);
    cyc(1'b0, '0, 1'b1);
    chk("t3_ack_pkt", 64'(pkt_rec), 64'd0);
    chk("t3_ack_ovr", 64'(overrun), 64'd0);

    // two phases on the same strobes
    send(F1, 4'b0110, 1'b0);
    chk("t2_ph", 64'(ph_idx), 64'd1);
    chk("t2_dup", 64'(dup), 64'd1);

    // match arriving on the ack cycle: ack wins, drop not recorded
    send(F1, 4'b0001, 1'b1);
    chk("ackwin_pkt", 64'(pkt_rec), 64'd0);
    chk("ackwin_ovr", 64'(overrun), 64'd0);
    cyc(1'b0, '0, 1'b0);
    chk("ackwin_idle", 64'(pkt_rec), 64'd0);

    // reset mid-frame
    send_bits(F1, 4'b0001, W - 1, W - 30);
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_dout", dout, 64'd0);
    chk("rst_pkt", 64'(pkt_rec), 64'd0);
    chk("rst_ph", 64'(ph_idx), 64'd0);
    cyc(1'b0, '0, 1'b0);
    rst = 1'b1;
    send(F1, 4'b0001, 1'b0);
    chk("t4_pkt", 64'(pkt_rec), 64'd1);
    chk("t4_dout", dout, F1);
    cyc(1'b0, '0, 1'b1);

    // sync error tolerance
    do_reset();
    send(F1 & ~(64'd1 << 60), 4'b0001, 1'b0);
`ifdef SYNC_ERR_TOL_EN
    chk("t5_one_err", 64'(pkt_rec), 64'd1);
`else
    chk("t5_one_err", 64'(pkt_rec), 64'd0);
`endif
    do_reset();
    send(F1 & ~(64'd1 << 60) & ~(64'd1 << 34), 4'b0001, 1'b0);
    chk("t5_two_err", 64'(pkt_rec), 64'd0);

    // stale pulse long before a held strobe, then a clean strobe
    do_reset();
    send_bits(T6, 4'b0001, W - 1, 58);
    cyc(1'b1, '0, 1'b0);
    repeat (4000) cyc(1'b0, '0, 1'b0);
    repeat (3) cyc(1'b0, 4'b0001, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, 4'b0001, 1'b0);
    cyc(1'b0, '0, 1'b0);
    send(T6, 4'b0001, 1'b0);
    chk("t6_pkt", 64'(pkt_rec), 64'd1);
    chk("t6_dout", dout, T6);
    cyc(1'b0, '0, 1'b1);

    // randomized frames on random phase groups
    do_reset();
    for (int k = 0; k < 10; k++) begin
      fr = (({$urandom, $urandom}) & ~MASK) | PAT;
      if ($urandom_range(0, 3) == 0) fr[$urandom_range(58, 62)] = 1'b0;
      send(fr, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) cyc(1'b0, '0, 1'b1);
    end

    // random soak
    for (int k = 0; k < 3000; k++)
      cyc(1'($urandom_range(0, 3) == 0), 4'($urandom), 1'($urandom_range(0, 7) == 0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/multi_phase_sync_buf.md
Name: multi_phase_sync_buf

Overview:
N-phase successor to the dual-phase RF receive buffer. Each phase owns a W-bit shift register clocked by its own shift-enable strobe, so each phase samples the same RF pulse stream at a different offset.
- Short rfin pulses are latched sticky per phase between strobes.
- A full frame whose masked sync bits match the pattern is reported with a level/ack handshake, together with the winning phase index.
- Sits between the RF envelope detector and the packet decoder.

Parameters:
N_PH, 4, number of sampling phases (2..8)
W, 64, frame width in bits
SYNC_MASK, 64'h7C00_001F_0000_001F, bit positions checked for sync (bits 62:58, 36:32, 4:0)
SYNC_PAT, 64'h7C00_001F_0000_001F, required values at masked positions
MAX_ERR, 1, tolerated sync mismatches (used only with SYNC_ERR_TOL_EN)

Ports:
clk  in  1  system clock (10 MHz nominal)
rst  in  1  asynchronous, active-low reset
rfin  in  1  RF detector pulse, typically 1 clk wide
sh_en  in  N_PH  per-phase shift strobe; rising edge shifts
pkt_ack  in  1  decoder accepts held packet
dout  out  W  captured frame of winning phase
pkt_rec  out  1  packet held, level until ack
ph_idx  out  clog2(N_PH)  phase that produced dout
dup  out  1  more than one phase matched on capture cycle
overrun  out  1  sticky: match dropped while holding

Behaviour:
- Reset (rst=0, async): all shift registers, hit latches, bit counters, sh_en history cleared; dout=0, pkt_rec=0, ph_idx=0, dup=0, overrun=0; FSM=IDLE.
- Hit latch per phase: hit[p] is set at any clk edge where rfin=1.
- Shift event for phase p occurs at an edge where sh_en[p]=1 and its registered previous value is 0. A strobe held for k cycles shifts exactly once.
- On a shift event:
  - sr[p] <= {sr[p][W-2:0], hit[p] | rfin}; MSB is the oldest bit.
  - hit[p] cleared; an rfin=1 on that same edge is consumed into the shifted bit and does not re-arm hit[p].
  - cnt[p] increments, saturating at W.
- match[p] (combinational) = (cnt[p]==W) && ((sr[p]^SYNC_PAT)&SYNC_MASK)==0.
- FSM IDLE, on any match:
  - Next edge: dout<=sr[lowest matching p], ph_idx<=that p, dup<=(popcount(match)>1), pkt_rec<=1 → HOLD.
  - Every matching phase has sr and cnt cleared on that same edge, which prevents re-detection of a shifted copy.
  - Latency: shift edge k → pkt_rec high after edge k+1.
- FSM HOLD:
  - dout, ph_idx and dup stay stable.
  - pkt_ack=1 → pkt_rec<=0, overrun<=0 → IDLE on the next edge.
  - Any match in HOLD, including the same cycle as pkt_ack, is dropped: overrun<=1 (unless that same edge clears it via pkt_ack, in which case ack wins and the drop is not recorded), and the matching phases are cleared.
- pkt_ack in IDLE is ignored.
- Shifting continues in all phases regardless of FSM state.
- sh_en edges on several phases in the same cycle are each processed independently.
- Reset mid-frame: a phase needs W fresh shifts before it can match again.

Optional Feature:
SYNC_ERR_TOL_EN
- Defined: match[p] = (cnt[p]==W) && popcount((sr[p]^SYNC_PAT)&SYNC_MASK) <= MAX_ERR. Popcount is a combinational adder tree over W bits.
- Undefined: exact masked compare only; MAX_ERR is unused.

Test Plan:
- Phase 0 strobed 64 times with frame 64'h7C15_A01F_0123_401F, rfin high at frame 1-bits, others idle → pkt_rec rises one cycle after the 64th shift; dout=7C15_A01F_0123_401F, ph_idx=0, dup=0.
- Same frame to phases 1 and 2 on the same strobe edges → ph_idx=1, dup=1; phases 1 and 2 cnt=0 afterward.
- After test 1, no ack, second valid frame on phase 3 → overrun=1, dout unchanged; pkt_ack → pkt_rec=0, overrun=0 next edge.
- rst pulled low after 30 shifts on phase 0 → all outputs 0 immediately; valid frame completes only after 64 further shifts.
- Frame with bit 60 cleared (one sync error) → no pkt_rec; with SYNC_ERR_TOL_EN and MAX_ERR=1 → pkt_rec=1; bits 60 and 34 cleared → no pkt_rec either way.
- rfin 1-cycle pulse 4000 cycles before a 3-cycle sh_en[0] strobe → exactly one shift, shifted bit = 1, hit[0] cleared; next strobe with no rfin shifts 0.
